// File: rtl/exc_int_arbiter.sv
// ============================================================================
// Module  : exc_int_arbiter
// Purpose : Sequences exception, interrupt, ERET and halt/resume commits from
//           the WB stage into CP0 as registered pulses, with flush/stall control.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module exc_int_arbiter #(
    parameter int unsigned FLUSH_CYCLES   = 2,
    parameter logic [4:0]  EX_CODE_INT    = 5'h00,
    parameter logic [4:0]  EX_CODE_HLT    = 5'h01,
    parameter logic [4:0]  EX_CODE_RESUME = 5'h02
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  int_sig,
    input  logic [7:0]  int_mask,
    input  logic        ie,
    input  logic        exl,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic        wb_bd,
    input  logic        wb_ex_req,
    input  logic [4:0]  wb_ex_code,
    input  logic        wb_eret,
    output logic        ex_wb_out,
    output logic [4:0]  ex_code_out,
    output logic [31:0] epc_out,
    output logic        bd_out,
    output logic        eret_flush_out,
    output logic        flush_out,
    output logic        stall_out,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COMMIT = 2'd1,
        S_FLUSH  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [3:0] C_FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t     r_state;
    logic       r_int_pend_q;
    logic [3:0] r_flush_cnt;

    // wake ignores ie/exl so a halted core can be resumed by any unmasked line
    logic w_wake;
    logic w_int_req;

    assign w_wake    = |(int_sig & int_mask);
    assign w_int_req = ie & ~exl & w_wake;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_int_pend_q   <= 1'b0;
            r_flush_cnt    <= 4'd0;
            ex_wb_out      <= 1'b0;
            ex_code_out    <= 5'd0;
            epc_out        <= 32'd0;
            bd_out         <= 1'b0;
            eret_flush_out <= 1'b0;
            flush_out      <= 1'b0;
            stall_out      <= 1'b0;
            halted         <= 1'b0;
        end else begin
            r_int_pend_q   <= w_int_req;
            ex_wb_out      <= 1'b0;
            eret_flush_out <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wb_valid) begin
                        if (r_int_pend_q || wb_ex_req) begin
                            // a pending interrupt pre-empts the WB instruction
                            ex_wb_out   <= 1'b1;
                            ex_code_out <= r_int_pend_q ? EX_CODE_INT : wb_ex_code;
                            epc_out     <= wb_pc;
                            bd_out      <= wb_bd;
                            stall_out   <= 1'b1;
                            r_state     <= S_COMMIT;
                        end else if (wb_eret) begin
                            eret_flush_out <= 1'b1;
                            flush_out      <= 1'b1;
                            stall_out      <= 1'b1;
                            r_flush_cnt    <= C_FLUSH_LOAD;
                            r_state        <= S_FLUSH;
                        end
                    end
                end
                S_COMMIT: begin
                    stall_out <= 1'b1;
                    if (ex_code_out == EX_CODE_HLT) begin
                        halted  <= 1'b1;
                        r_state <= S_HALTED;
                    end else begin
                        flush_out   <= 1'b1;
                        r_flush_cnt <= C_FLUSH_LOAD;
                        r_state     <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (r_flush_cnt <= 4'd1) begin
                        flush_out   <= 1'b0;
                        stall_out   <= 1'b0;
                        r_flush_cnt <= 4'd0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 4'd1;
                    end
                end
                S_HALTED: begin
                    if (w_wake) begin
                        ex_wb_out   <= 1'b1;
                        ex_code_out <= EX_CODE_RESUME;
                        epc_out     <= 32'd0;
                        bd_out      <= 1'b0;
                        halted      <= 1'b0;
                        flush_out   <= 1'b1;
                        stall_out   <= 1'b1;
                        r_flush_cnt <= C_FLUSH_LOAD;
                        r_state     <= S_FLUSH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_exc_int_arbiter.sv
// ============================================================================
// Module  : tb_exc_int_arbiter
// Purpose : Directed scenarios plus randomized traffic against a schedule model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exc_int_arbiter;

    localparam int         FC  = 2;
    localparam logic [4:0] INT = 5'h00;
    localparam logic [4:0] HLT = 5'h01;
    localparam logic [4:0] RES = 5'h02;
    localparam int         RING = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  int_sig = '0, int_mask = '0;
    logic        ie = 1'b0, exl = 1'b0, wb_valid = 1'b0, wb_bd = 1'b0;
    logic [31:0] wb_pc = '0;
    logic        wb_ex_req = 1'b0, wb_eret = 1'b0;
    logic [4:0]  wb_ex_code = '0;
    logic        ex_wb_out, bd_out, eret_flush_out, flush_out, stall_out, halted;
    logic [4:0]  ex_code_out;
    logic [31:0] epc_out;

    int checks = 0;
    int errors = 0;

    exc_int_arbiter #(
        .FLUSH_CYCLES(FC), .EX_CODE_INT(INT), .EX_CODE_HLT(HLT), .EX_CODE_RESUME(RES)
    ) dut (
        .clk(clk), .rst(rst), .int_sig(int_sig), .int_mask(int_mask), .ie(ie), .exl(exl),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_bd(wb_bd), .wb_ex_req(wb_ex_req),
        .wb_ex_code(wb_ex_code), .wb_eret(wb_eret), .ex_wb_out(ex_wb_out),
        .ex_code_out(ex_code_out), .epc_out(epc_out), .bd_out(bd_out),
        .eret_flush_out(eret_flush_out), .flush_out(flush_out), .stall_out(stall_out),
        .halted(halted)
    );

    always #5 clk = ~clk;

    // Reference model: each decision schedules its output timeline into a ring
    // indexed by absolute cycle; the arbiter is "free" from m_free_at onward.
    bit          r_ex[RING], r_er[RING], r_fl[RING], r_st[RING];
    logic [4:0]  r_code[RING];
    logic [31:0] r_pc[RING];
    bit          r_bd[RING];
    int          cyc = 0;
    bit          m_pend = 0, m_halted = 0;
    int          m_free_at = 0, m_halt_start = 0;
    bit          e_ex, e_er, e_fl, e_st, e_hl, e_bd;
    logic [4:0]  e_code;
    logic [31:0] e_pc;

    task automatic clear_ring();
        for (int i = 0; i < RING; i++) begin
            r_ex[i] = 0; r_er[i] = 0; r_fl[i] = 0; r_st[i] = 0;
            r_code[i] = '0; r_pc[i] = '0; r_bd[i] = 0;
        end
    endtask

    task automatic sched_flush(input int from, input int len);
        for (int k = 0; k < len; k++) begin
            r_fl[(from + k) % RING] = 1; r_st[(from + k) % RING] = 1;
        end
    endtask

    task automatic sched_ex(input int c, input logic [4:0] code, input logic [31:0] pc, input bit bd);
        r_ex[c % RING] = 1; r_st[c % RING] = 1;
        r_code[c % RING] = code; r_pc[c % RING] = pc; r_bd[c % RING] = bd;
    endtask

    task automatic model_edge(input int n);
        bit pend_old;
        bit hit;
        logic [4:0] code;
        hit = |(int_sig & int_mask);
        if (rst) begin
            clear_ring();
            m_pend = 0; m_halted = 0; m_free_at = n + 1;
        end else begin
            pend_old = m_pend;
            m_pend   = ie && !exl && hit;
            if (m_halted) begin
                if (n > m_halt_start && hit) begin
                    m_halted = 0;
                    sched_ex(n, RES, 32'd0, 1'b0);
                    sched_flush(n, FC);
                    m_free_at = n + FC + 1;
                end
            end else if (n >= m_free_at && wb_valid) begin
                if (pend_old || wb_ex_req) begin
                    code = pend_old ? INT : wb_ex_code;
                    sched_ex(n, code, wb_pc, wb_bd);
                    if (code == HLT) begin
                        m_halted = 1; m_halt_start = n + 1; m_free_at = 32'h7fff_ffff;
                    end else begin
                        sched_flush(n + 1, FC);
                        m_free_at = n + FC + 2;
                    end
                end else if (wb_eret) begin
                    r_er[n % RING] = 1;
                    sched_flush(n, FC);
                    m_free_at = n + FC + 1;
                end
            end
        end
        e_ex = r_ex[n % RING]; e_er = r_er[n % RING]; e_fl = r_fl[n % RING];
        e_hl = m_halted && (n >= m_halt_start);
        e_st = r_st[n % RING] || e_hl;
        e_code = r_code[n % RING]; e_pc = r_pc[n % RING]; e_bd = r_bd[n % RING];
        r_ex[n % RING] = 0; r_er[n % RING] = 0; r_fl[n % RING] = 0; r_st[n % RING] = 0;
    endtask

    task automatic tick();
        model_edge(cyc);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        int_sig = '0; wb_valid = 0; wb_ex_req = 0; wb_eret = 0; wb_bd = 0; rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; tick(); tick(); rst = 0;
        checks++;
        if ({ex_wb_out, eret_flush_out, flush_out, stall_out, halted, bd_out} !== 6'b0 ||
            ex_code_out !== 5'd0 || epc_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ctl=%b code=%h epc=%h, want all zero",
                     {ex_wb_out, eret_flush_out, flush_out, stall_out, halted, bd_out},
                     ex_code_out, epc_out);
        end
    endtask

    task automatic test_interrupt();
        idle_inputs(); ie = 1; exl = 0; int_mask = 8'hFF; int_sig = 8'h04;
        wb_valid = 1; wb_pc = 32'h0040_0100;
        tick();
        checks++;
        if (ex_wb_out !== 1'b0) begin
            errors++; $display("FAIL int_latency: ex_wb_out got %b want 0 after 1 cycle", ex_wb_out);
        end
        tick();
        checks++;
        if (ex_wb_out !== 1'b1 || ex_code_out !== INT || epc_out !== 32'h0040_0100) begin
            errors++;
            $display("FAIL int_commit: got ex=%b code=%h epc=%h want 1/%h/00400100",
                     ex_wb_out, ex_code_out, epc_out, INT);
        end
        idle_inputs();
        tick(); tick();
        checks++;
        if (flush_out !== 1'b1 || ex_wb_out !== 1'b0) begin
            errors++; $display("FAIL int_flush: got flush=%b ex=%b want 1/0", flush_out, ex_wb_out);
        end
        tick();
        checks++;
        if (flush_out !== 1'b0 || stall_out !== 1'b0) begin
            errors++; $display("FAIL int_idle: got flush=%b stall=%b want 0/0", flush_out, stall_out);
        end
        tick();
    endtask

    task automatic test_masked();
        int pulses = 0;
        idle_inputs(); ie = 1; exl = 0; int_mask = 8'h00; int_sig = 8'hFF; wb_valid = 1;
        for (int i = 0; i < 20; i++) begin tick(); pulses += int'(ex_wb_out); end
        int_mask = 8'hFF; exl = 1;
        for (int i = 0; i < 20; i++) begin tick(); pulses += int'(ex_wb_out); end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL masked_int: got %0d ex_wb_out pulses want 0", pulses);
        end
        idle_inputs(); exl = 0; tick(); tick();
    endtask

    task automatic test_ex_vs_eret();
        int exs = 0, erets = 0;
        idle_inputs(); ie = 0; wb_valid = 1; wb_ex_req = 1; wb_ex_code = 5'h0C;
        wb_eret = 1; wb_bd = 1; wb_pc = 32'h0040_0200;
        tick();
        erets += int'(eret_flush_out); exs += int'(ex_wb_out);
        checks++;
        if (ex_wb_out !== 1'b1 || ex_code_out !== 5'h0C || bd_out !== 1'b1 || epc_out !== 32'h0040_0200) begin
            errors++;
            $display("FAIL ex_vs_eret: got ex=%b code=%h bd=%b epc=%h want 1/0c/1/00400200",
                     ex_wb_out, ex_code_out, bd_out, epc_out);
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            tick(); erets += int'(eret_flush_out); exs += int'(ex_wb_out);
        end
        checks++;
        if (exs != 1 || erets != 0) begin
            errors++; $display("FAIL ex_vs_eret_count: got ex=%0d eret=%0d want 1/0", exs, erets);
        end
    endtask

    task automatic test_halt_resume();
        int held = 0;
        idle_inputs(); ie = 0; int_mask = 8'hFF; wb_valid = 1; wb_ex_req = 1;
        wb_ex_code = HLT; wb_pc = 32'h0040_0300;
        tick();
        checks++;
        if (ex_wb_out !== 1'b1 || ex_code_out !== HLT) begin
            errors++; $display("FAIL halt_commit: got ex=%b code=%h want 1/%h", ex_wb_out, ex_code_out, HLT);
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            tick(); held += int'(halted && stall_out && !flush_out && !ex_wb_out);
        end
        checks++;
        if (held != 6) begin
            errors++; $display("FAIL halt_hold: got %0d of 6 halted cycles want 6", held);
        end
        int_sig = 8'h80;
        tick();
        checks++;
        if (ex_wb_out !== 1'b1 || ex_code_out !== RES || epc_out !== 32'd0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL resume_commit: got ex=%b code=%h epc=%h halted=%b want 1/%h/0/0",
                     ex_wb_out, ex_code_out, epc_out, halted, RES);
        end
        int_sig = 8'h00;
        tick();
        checks++;
        if (flush_out !== 1'b1 || ex_wb_out !== 1'b0) begin
            errors++; $display("FAIL resume_flush: got flush=%b ex=%b want 1/0", flush_out, ex_wb_out);
        end
        tick();
        checks++;
        if (flush_out !== 1'b0 || stall_out !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL resume_idle: got flush=%b stall=%b halted=%b want 0/0/0", flush_out, stall_out, halted);
        end
    endtask

    task automatic test_hold_until_valid();
        int pulses = 0;
        idle_inputs(); ie = 1; exl = 0; int_mask = 8'hFF; int_sig = 8'h01;
        for (int i = 0; i < 5; i++) begin tick(); pulses += int'(ex_wb_out); end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL int_hold: got %0d pulses with wb_valid=0 want 0", pulses);
        end
        wb_valid = 1; wb_pc = 32'h0040_0444; wb_bd = 0;
        tick();
        checks++;
        if (ex_wb_out !== 1'b1 || ex_code_out !== INT || epc_out !== 32'h0040_0444) begin
            errors++;
            $display("FAIL int_held_commit: got ex=%b code=%h epc=%h want 1/%h/00400444",
                     ex_wb_out, ex_code_out, epc_out, INT);
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_reset_mid_flush();
        int pulses = 0;
        idle_inputs(); wb_valid = 1; wb_eret = 1;
        tick();
        checks++;
        if (eret_flush_out !== 1'b1 || flush_out !== 1'b1 || ex_wb_out !== 1'b0) begin
            errors++;
            $display("FAIL eret_commit: got eret=%b flush=%b ex=%b want 1/1/0", eret_flush_out, flush_out, ex_wb_out);
        end
        idle_inputs(); rst = 1;
        tick();
        rst = 0;
        checks++;
        if ({ex_wb_out, eret_flush_out, flush_out, stall_out, halted} !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid_flush: got %b want 00000",
                     {ex_wb_out, eret_flush_out, flush_out, stall_out, halted});
        end
        for (int i = 0; i < 6; i++) begin
            tick(); pulses += int'(ex_wb_out || eret_flush_out || flush_out || stall_out);
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL post_reset_quiet: got %0d active cycles want 0", pulses);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            wb_valid   = $urandom_range(0, 1) == 1;
            wb_ex_req  = ($urandom_range(0, 7) == 0);
            wb_eret    = ($urandom_range(0, 7) == 0);
            wb_ex_code = ($urandom_range(0, 3) == 0) ? HLT : 5'($urandom);
            wb_bd      = $urandom_range(0, 1) == 1;
            wb_pc      = $urandom;
            int_sig    = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
            int_mask   = 8'($urandom);
            ie         = $urandom_range(0, 1) == 1;
            exl        = ($urandom_range(0, 3) == 0);
            tick();
            checks++;
            if ({ex_wb_out, eret_flush_out, flush_out, stall_out, halted} !== {e_ex, e_er, e_fl, e_st, e_hl}) begin
                errors++;
                $display("FAIL rand_ctrl cyc=%0d: got ex/eret/flush/stall/halt=%b want %b", cyc,
                         {ex_wb_out, eret_flush_out, flush_out, stall_out, halted},
                         {e_ex, e_er, e_fl, e_st, e_hl});
            end
            if (e_ex) begin
                checks++;
                if (ex_code_out !== e_code || epc_out !== e_pc || bd_out !== e_bd) begin
                    errors++;
                    $display("FAIL rand_payload cyc=%0d: got code=%h epc=%h bd=%b want %h/%h/%b", cyc,
                             ex_code_out, epc_out, bd_out, e_code, e_pc, e_bd);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        clear_ring();
        test_reset();
        test_interrupt();
        test_masked();
        test_ex_vs_eret();
        test_halt_resume();
        test_hold_until_valid();
        test_reset_mid_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/exc_int_arbiter.md
Name: exc_int_arbiter

Overview:
Sequences exception, interrupt, ERET and halt/resume events into the CP0 register block. Sits between the WB pipeline stage and CP0.
- Arbitrates WB-stage synchronous exceptions against masked hardware/software interrupts.
- Drives CP0's exception/flush inputs as clean registered pulses.
- Holds the front-end stalled through flush and halt.

Parameters:
FLUSH_CYCLES, 2, cycles flush_out stays high after an event commit (1..15)
EX_CODE_INT, 5'h00, code issued for a taken interrupt
EX_CODE_HLT, 5'h01, code that enters the halted state
EX_CODE_RESUME, 5'h02, code issued when leaving the halted state

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
int_sig  in  8  CAUSE.IP[7:0] from CP0
int_mask  in  8  STATUS.IM[7:0] from CP0
ie  in  1  STATUS.IE
exl  in  1  STATUS.EXL
wb_valid  in  1  valid instruction in WB this cycle
wb_pc  in  32  PC of WB instruction
wb_bd  in  1  WB instruction is in a branch delay slot
wb_ex_req  in  1  WB instruction raised a synchronous exception
wb_ex_code  in  5  code for wb_ex_req
wb_eret  in  1  WB instruction is ERET
ex_wb_out  out  1  one-cycle exception commit pulse to CP0
ex_code_out  out  5  exception code, valid with ex_wb_out
epc_out  out  32  PC handed to CP0, valid with ex_wb_out
bd_out  out  1  branch-delay flag, valid with ex_wb_out
eret_flush_out  out  1  one-cycle ERET commit pulse to CP0
flush_out  out  1  pipeline flush
stall_out  out  1  front-end freeze
halted  out  1  high while in HALTED

Behaviour:
- Reset: state IDLE; all outputs 0; int_pend_q=0; flush counter=0.
- int_req = ie & ~exl & |(int_sig & int_mask). It is registered into int_pend_q, which adds 1 cycle of sync latency.
- wake = |(int_sig & int_mask), combinational, ignoring ie/exl. Used only in HALTED.
- All outputs are registered. Each event decided in cycle N is visible in cycle N+1.
- States: IDLE, COMMIT, FLUSH, HALTED.
- IDLE, decision priority when wb_valid=1:
  1. int_pend_q: code=EX_CODE_INT, epc=wb_pc, bd=wb_bd (the interrupt pre-empts the WB instruction).
  2. wb_ex_req: code=wb_ex_code, epc=wb_pc, bd=wb_bd.
  3. wb_eret: eret_flush_out pulses 1 cycle; go to FLUSH.
  4. Otherwise stay in IDLE.
- IDLE with wb_valid=0: no event is taken; an interrupt stays pending in int_pend_q.
- COMMIT, entered on priority 1 or 2:
  - ex_wb_out=1 for exactly 1 cycle, with ex_code_out/epc_out/bd_out held stable in that cycle.
  - stall_out=1.
  - Next state: HALTED if code==EX_CODE_HLT, else FLUSH.
- FLUSH:
  - flush_out=1 and stall_out=1 for FLUSH_CYCLES cycles, counted by a 4-bit down-counter loaded on entry.
  - Returns to IDLE when the count reaches 0.
  - WB inputs are ignored while in FLUSH.
- HALTED:
  - halted=1, stall_out=1, flush_out=0.
  - On wake: ex_wb_out pulses with code EX_CODE_RESUME, epc_out=0, bd_out=0; go to FLUSH. halted drops in the same cycle as the pulse.
- Simultaneous events:
  - wb_ex_req together with wb_eret: exception wins, ERET is dropped.
  - Interrupt together with wb_ex_req: the interrupt wins; the instruction re-executes after return.
- ex_wb_out and eret_flush_out are never high in the same cycle.
- At most one event is committed per FLUSH window.
- Reset mid-FLUSH or mid-HALTED: return to IDLE next cycle with all outputs 0.
- Pulses already in flight are cancelled by reset.

Test Plan:
1. Interrupt: ie=1, exl=0, int_mask=FF, int_sig=04, wb_valid=1, wb_pc=0x00400100. Expect 2 cycles later ex_wb_out=1, code=00, epc=0x00400100; then flush_out high for 2 cycles; then IDLE.
2. Masked interrupt: int_mask=00 (or exl=1), int_sig=FF. Expect no ex_wb_out for 20 cycles.
3. Exception vs ERET: wb_ex_req=1, code=0C, wb_eret=1, wb_bd=1, wb_pc=0x0040_0200. Expect one ex_wb_out with code=0C, bd=1, epc=0x00400200, and eret_flush_out never high.
4. Halt and resume: wb_ex_req with code=01. Expect ex_wb_out pulse, then halted=1 and stall_out=1 held. Raise int_sig=80 with ie=0. Expect ex_wb_out with code=02, epc=0, then flush 2 cycles, then halted=0.
5. Interrupt held until WB valid: int pending with wb_valid=0 for 5 cycles. Expect no event. On wb_valid=1, expect the interrupt committed with that wb_pc.
6. Reset mid-flush: assert rst during the FLUSH_CYCLES window. Expect the next cycle to show all outputs 0 and state IDLE, with no further pulses.
